// File: rtl/zl_energy_dispersal_pkg.sv
// Shared constants for the DVB-S energy dispersal randomizer and its receive-side twin.
// Sync byte values, PRBS seed/taps and control state encoding.
package zl_energy_dispersal_pkg;

  localparam logic [7:0]  TS_SYNC     = 8'h47;
  localparam logic [7:0]  TS_SYNC_INV = 8'hB8;

  // Register bit i holds shift stage i+1; seed is stages 1..15 = 100101010000000
  localparam logic [14:0] PRBS_INIT   = 15'h00A9;
  localparam int          PRBS_TAP_A  = 14;
  localparam int          PRBS_TAP_B  = 15;

  localparam logic [0:0]  ST_HUNT     = 1'b0;
  localparam logic [0:0]  ST_RUN      = 1'b1;

endpackage

// File: rtl/zl_dvb_prbs.sv
// Combinational 8-step advance of the 1+x^14+x^15 dispersal PRBS.
// mask[7] is the first feedback bit produced, so the mask applies MSB first.
module zl_dvb_prbs
  import zl_energy_dispersal_pkg::*;
(
  input  logic [14:0] p,
  output logic [14:0] next_p,
  output logic [7:0]  mask
);

  logic [14:0] s;
  logic        fb;

  always_comb begin
    s    = p;
    fb   = 1'b0;
    mask = '0;
    for (int i = 7; i >= 0; i--) begin
      fb      = s[PRBS_TAP_A-1] ^ s[PRBS_TAP_B-1];
      mask[i] = fb;
      s       = {s[13:0], fb};
    end
    next_p = s;
  end

endmodule

// File: rtl/zl_energy_dispersal.sv
// DVB-S transport-stream randomizer: PRBS-whitens payload, inverts the sync of every group's first packet.
// One registered output stage, 1-cycle latency, one byte per clock; input stalls while the output is held.
module zl_energy_dispersal
  import zl_energy_dispersal_pkg::*;
#(
  parameter int PktLen   = 188,
  parameter int GroupLen = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in_req,
  output logic       data_in_ack,
  input  logic [7:0] data_in,
  input  logic       data_in_start,
  output logic       data_out_req,
  input  logic       data_out_ack,
  output logic [7:0] data_out,
  output logic       data_out_start,
  output logic       locked,
  output logic       sync_err
);

  localparam int IdxW = (GroupLen > 1) ? $clog2(GroupLen) : 1;

  logic [0:0]      state, state_nxt;
  logic [7:0]      byte_cnt, cnt_nxt;
  logic [IdxW-1:0] pkt_idx, idx_nxt;
  logic [14:0]     prbs, prbs_nxt, prbs_adv;
  logic [7:0]      mask, out_nxt;
  logic            err_nxt, restart, last_byte, group_wrap;

  zl_dvb_prbs u_prbs (
    .p      (prbs),
    .next_p (prbs_adv),
    .mask   (mask)
  );

  assign data_in_ack = data_in_req && (!data_out_req || data_out_ack);
  assign locked      = (state == ST_RUN);
  assign last_byte   = (byte_cnt == 8'(PktLen));
  assign group_wrap  = (pkt_idx == IdxW'(GroupLen - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = byte_cnt;
    idx_nxt   = pkt_idx;
    prbs_nxt  = prbs;
    out_nxt   = data_in;
    err_nxt   = 1'b0;
    restart   = 1'b0;
    if (state == ST_HUNT) begin
      restart = data_in_start;
    end else if (data_in_start) begin
      if (last_byte) begin
        cnt_nxt = 8'd1;
        idx_nxt = group_wrap ? '0 : pkt_idx + 1'b1;
        // Syncs inside a group are not randomized but still consume one PRBS byte
        if (group_wrap) begin
          out_nxt  = ~data_in;
          prbs_nxt = PRBS_INIT;
        end else begin
          prbs_nxt = prbs_adv;
        end
      end else begin
        err_nxt = 1'b1;
        restart = 1'b1;
      end
    end else if (last_byte) begin
      err_nxt   = 1'b1;
      state_nxt = ST_HUNT;
      cnt_nxt   = 8'd0;
    end else begin
      out_nxt  = data_in ^ mask;
      prbs_nxt = prbs_adv;
      cnt_nxt  = byte_cnt + 8'd1;
    end
    // A start seen in HUNT, or out of place in RUN, begins a fresh group
    if (restart) begin
      out_nxt   = ~data_in;
      prbs_nxt  = PRBS_INIT;
      idx_nxt   = '0;
      cnt_nxt   = 8'd1;
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_HUNT;
      byte_cnt       <= 8'd0;
      pkt_idx        <= '0;
      prbs           <= PRBS_INIT;
      data_out_req   <= 1'b0;
      data_out       <= 8'h00;
      data_out_start <= 1'b0;
      sync_err       <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (data_in_ack) begin
        state          <= state_nxt;
        byte_cnt       <= cnt_nxt;
        pkt_idx        <= idx_nxt;
        prbs           <= prbs_nxt;
        data_out       <= out_nxt;
        data_out_start <= data_in_start;
        data_out_req   <= 1'b1;
        sync_err       <= err_nxt;
      end else if (data_out_ack) begin
        data_out_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zl_energy_dispersal.sv
// Self-checking bench for zl_energy_dispersal: scoreboard model, spot-value table, stall and framing corners.
module tb_zl_energy_dispersal;
  import zl_energy_dispersal_pkg::*;

  localparam int PKT     = 188;
  localparam int GRP     = 8;
  localparam int PERIOD  = 1503;
  localparam int NSTREAM = 9 * PKT;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       data_in_req = 1'b0, data_in_start = 1'b0, data_out_ack = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_ack, data_out_req, data_out_start, locked, sync_err;
  logic [7:0] data_out;

  zl_energy_dispersal #(.PktLen(PKT), .GroupLen(GRP)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in_req(data_in_req), .data_in_ack(data_in_ack),
    .data_in(data_in), .data_in_start(data_in_start),
    .data_out_req(data_out_req), .data_out_ack(data_out_ack),
    .data_out(data_out), .data_out_start(data_out_start),
    .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference PRBS mask bytes, bit-serial over shift stages 1..15
  logic [7:0] mtab [0:PERIOD-1];
  task automatic gen_mtab();
    logic [15:1] s;
    logic        b;
    s = '0; s[1] = 1'b1; s[4] = 1'b1; s[6] = 1'b1; s[8] = 1'b1;
    for (int k = 0; k < PERIOD; k++) begin
      for (int j = 7; j >= 0; j--) begin
        b = s[14] ^ s[15];
        mtab[k][j] = b;
        s = {s[14:1], b};
      end
    end
  endtask

  int m_run, m_cnt, m_idx, m_pos;
  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_idx = 0; m_pos = 0;
  endtask

  task automatic model_step(input logic [7:0] d, input logic s, output logic [7:0] o, output logic os);
    logic restart;
    restart = 1'b0; o = d; os = s;
    if (m_run == 0) restart = s;
    else if (s) begin
      if (m_cnt == PKT) begin
        m_cnt = 1;
        m_idx = (m_idx + 1) % GRP;
        if (m_idx == 0) begin o = ~d; m_pos = 0; end
        else m_pos = (m_pos + 1) % PERIOD;
      end else restart = 1'b1;
    end else if (m_cnt == PKT) begin
      m_run = 0; m_cnt = 0;
    end else begin
      o = d ^ mtab[m_pos];
      m_pos = (m_pos + 1) % PERIOD;
      m_cnt++;
    end
    if (restart) begin o = ~d; m_pos = 0; m_idx = 0; m_cnt = 1; m_run = 1; end
  endtask

  typedef struct { logic [7:0] d; logic s; } exp_t;
  exp_t q[$];

  logic [7:0] log_d[$];
  logic       log_s[$];
  logic       log_lk[$];
  int         log_c[$];
  logic [7:0] ref_d [0:NSTREAM-1];

  int   cyc = 0;
  int   err_pulses = 0;
  logic stall_en = 1'b0, hold_ack = 1'b0;
  logic held = 1'b0, held_s;
  logic [7:0] held_d;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    data_out_ack = data_out_req && !hold_ack && (!stall_en || $urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) held = 1'b0;
    else begin
      if (held) begin
        check("hold_req", data_out_req, 1);
        check("hold_dat", {data_out_start, data_out}, {held_s, held_d});
      end
      if (sync_err) err_pulses++;
      if (data_out_req && data_out_ack) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %0h expected none", data_out);
        end else begin
          e = q.pop_front();
          check("out_dat", data_out, e.d);
          check("out_start", data_out_start, e.s);
        end
        log_d.push_back(data_out); log_s.push_back(data_out_start);
        log_lk.push_back(locked);  log_c.push_back(cyc);
        held = 1'b0;
      end else if (data_out_req) begin
        held = 1'b1; held_d = data_out; held_s = data_out_start;
      end else held = 1'b0;
    end
  end

  int acc_cyc;
  task automatic send_byte(input logic [7:0] d, input logic s);
    int budget;
    logic [7:0] eo;
    logic es;
    budget = 0;
    @(posedge clk); #1;
    while (stall_en && $urandom_range(0, 3) == 0) begin
      data_in_req = 1'b0; @(posedge clk); #1;
    end
    data_in_req = 1'b1; data_in = d; data_in_start = s;
    @(negedge clk);
    while (!data_in_ack) begin
      budget++;
      if (budget > 1000) begin
        checks++; errors++;
        $display("FAIL accept_timeout: got no ack expected ack within 1000 cycles");
        data_in_req = 1'b0;
        return;
      end
      @(negedge clk);
    end
    acc_cyc = cyc;
    model_step(d, s, eo, es);
    q.push_back('{d: eo, s: es});
  endtask

  task automatic send_pkt(input int n);
    send_byte(TS_SYNC, 1'b1);
    for (int i = 1; i < n; i++) send_byte(8'h00, 1'b0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    data_in_req = 1'b0; data_in_start = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || data_out_req) && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_req"}, data_out_req, 0);
    check({tag, "_dat"}, data_out, 8'h00);
    check({tag, "_start"}, data_out_start, 0);
    check({tag, "_locked"}, locked, 0);
    check({tag, "_err"}, sync_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst");
    q.delete(); model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    err_pulses = 0;
    log_d.delete(); log_s.delete(); log_lk.delete(); log_c.delete();
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] d);
    if (idx >= log_d.size()) begin
      checks++; errors++;
      $display("FAIL %s: got no byte at %0d expected %0h", name, idx, d);
    end else check(name, log_d[idx], d);
  endtask

  typedef struct { string name; int idx; logic [7:0] d; logic s; } vec_t;
  vec_t vt [10];

  initial begin
    int nd, first_acc;
    vt[0] = '{"p0_sync",   0,    8'hB8, 1'b1};
    vt[1] = '{"p0_b1",     1,    8'h03, 1'b0};
    vt[2] = '{"p0_b2",     2,    8'hF6, 1'b0};
    vt[3] = '{"p1_sync",   188,  8'h47, 1'b1};
    vt[4] = '{"p2_sync",   376,  8'h47, 1'b1};
    vt[5] = '{"p4_sync",   752,  8'h47, 1'b1};
    vt[6] = '{"p7_sync",   1316, 8'h47, 1'b1};
    vt[7] = '{"p8_sync",   1504, 8'hB8, 1'b1};
    vt[8] = '{"p8_b1",     1505, 8'h03, 1'b0};
    vt[9] = '{"p8_b2",     1506, 8'hF6, 1'b0};
    gen_mtab();
    model_reset();

    #1;
    check_reset_outs("init");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Clean run: nine packets of zero payload, no stalls
    send_byte(TS_SYNC, 1'b1);
    first_acc = acc_cyc;
    for (int i = 1; i < PKT; i++) send_byte(8'h00, 1'b0);
    for (int p = 1; p < 9; p++) send_pkt(PKT);
    idle(); drain();
    check("run1_len", log_d.size(), NSTREAM);
    if (log_d.size() == NSTREAM) begin
      for (int i = 0; i < 10; i++) begin
        check({vt[i].name, "_dat"}, log_d[vt[i].idx], vt[i].d);
        check({vt[i].name, "_start"}, log_s[vt[i].idx], vt[i].s);
      end
      check("latency", log_c[0], first_acc + 1);
      check("throughput", log_c[NSTREAM-1] - log_c[0], NSTREAM - 1);
      check("locked_first", log_lk[0], 1);
      nd = 0;
      for (int k = 0; k < PKT; k++) if (log_d[8*PKT + k] !== log_d[k]) nd++;
      check("p8_eq_p0", nd, 0);
      nd = 0;
      for (int k = 1; k < PKT; k++) if (log_d[k] !== mtab[k-1]) nd++;
      check("p0_mask", nd, 0);
      for (int k = 0; k < NSTREAM; k++) ref_d[k] = log_d[k];
    end
    check("run1_err", err_pulses, 0);
    check("run1_locked", locked, 1);

    // Same stream with random input gaps and output backpressure
    do_reset();
    stall_en = 1'b1;
    for (int p = 0; p < 9; p++) send_pkt(PKT);
    idle();
    stall_en = 1'b0;
    drain();
    check("run2_len", log_d.size(), NSTREAM);
    nd = 0;
    if (log_d.size() == NSTREAM)
      for (int k = 0; k < NSTREAM; k++) if (log_d[k] !== ref_d[k]) nd++;
    check("run2_same", nd, 0);
    check("run2_err", err_pulses, 0);

    // Early start at byte 100 of packet 3, then a missing start
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(PKT);
    send_pkt(100);
    send_pkt(PKT);
    idle(); drain();
    check("early_err", err_pulses, 1);
    check("early_locked", locked, 1);
    check_log("early_sync", 3*PKT + 100, 8'hB8);
    check_log("early_b1", 3*PKT + 101, 8'h03);
    check_log("early_b2", 3*PKT + 102, 8'hF6);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA0, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(); drain();
    check("miss_err", err_pulses, 2);
    check("miss_locked", locked, 0);
    check_log("miss_b0", 4*PKT + 100, 8'h55);
    check_log("miss_b1", 4*PKT + 101, 8'h55);
    check_log("miss_b2", 4*PKT + 102, 8'hA0);
    check_log("miss_b3", 4*PKT + 103, 8'h00);
    send_byte(TS_SYNC, 1'b1);
    send_byte(8'h00, 1'b0);
    idle(); drain();
    check_log("relock_sync", 4*PKT + 104, TS_SYNC_INV);
    check_log("relock_b1", 4*PKT + 105, 8'h03);
    check("relock_locked", locked, 1);

    // Reset while a byte sits in the output register
    hold_ack = 1'b1;
    send_byte(8'h12, 1'b0);
    idle();
    @(negedge clk);
    check("pre_rst_req", data_out_req, 1);
    hold_ack = 1'b0;
    do_reset();
    send_byte(TS_SYNC, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle(); drain();
    check_log("post_rst_sync", 0, TS_SYNC_INV);
    check_log("post_rst_b1", 1, 8'h03);
    check_log("post_rst_b2", 2, 8'hF6);
    check("post_rst_len", log_d.size(), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
